// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: display view encodings and default time width.
// The display multiplexer decodes these same view codes.
package stopwatch_pkg;
    localparam int TIME_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        SEL_RUN  = 2'b00,
        SEL_LAP1 = 2'b01,
        SEL_LAP2 = 2'b10
    } view_e;

    // View advance on a button event; LAP2 is only reachable once two laps are held.
    function automatic view_e next_view(input view_e cur, input logic [1:0] laps);
        case (cur)
            SEL_RUN:  next_view = (laps >= 2'd1) ? SEL_LAP1 : SEL_RUN;
            SEL_LAP1: next_view = (laps == 2'd2) ? SEL_LAP2 : SEL_RUN;
            default:  next_view = SEL_RUN;
        endcase
    endfunction
endpackage

// File: rtl/lap_controller_if.sv
// Lap controller bus: stopwatch time and buttons in, lap registers and view code out.
interface lap_controller_if
    import stopwatch_pkg::*;
#(
    parameter int TIME_W = TIME_W_DEFAULT
);
    logic [TIME_W-1:0] running_time;
    logic              lap_btn;
    logic              view_btn;
    logic              clear;
    logic [TIME_W-1:0] lap1;
    logic [TIME_W-1:0] lap2;
    logic [1:0]        display_select;
    logic [1:0]        lap_count;

    modport master (
        output running_time, lap_btn, view_btn, clear,
        input  lap1, lap2, display_select, lap_count
    );

    modport slave (
        input  running_time, lap_btn, view_btn, clear,
        output lap1, lap2, display_select, lap_count
    );
endinterface

// File: rtl/lap_controller_rise_edge.sv
// Registered rising-edge detector: one event per low-to-high transition of btn.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);
    logic btn_q;

    always_ff @(posedge clk) begin
        if (reset) btn_q <= 1'b0;
        else       btn_q <= btn;
    end

    assign evt = btn & ~btn_q;
endmodule

// File: rtl/lap_controller.sv
// Lap capture (two-deep shift) and display view FSM with automatic return
// from lap views after TIMEOUT_CYCLES idle cycles.
module lap_controller
    import stopwatch_pkg::*;
#(
    parameter int TIME_W         = TIME_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    lap_controller_if.slave  bus
);
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic              lap_evt;
    logic              view_evt;
    logic [TIME_W-1:0] lap1;
    logic [TIME_W-1:0] lap2;
    logic [1:0]        lap_count;
    view_e             state;
    logic [CNT_W-1:0]  tmo_cnt;

    rise_edge u_lap_edge  (.clk(clk), .reset(reset), .btn(bus.lap_btn),  .evt(lap_evt));
    rise_edge u_view_edge (.clk(clk), .reset(reset), .btn(bus.view_btn), .evt(view_evt));

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            lap1      <= '0;
            lap2      <= '0;
            lap_count <= 2'd0;
            state     <= SEL_RUN;
            tmo_cnt   <= '0;
        end else begin
            if (lap_evt) begin
                lap2 <= lap1;
                lap1 <= bus.running_time;
                if (lap_count != 2'd2) lap_count <= lap_count + 2'd1;
            end
            // lap_count here is the pre-edge value, so a same-cycle lap does not unlock a view
            if (view_evt) begin
                state   <= next_view(state, lap_count);
                tmo_cnt <= '0;
            end else if (state == SEL_RUN) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == CNT_LAST) begin
                state   <= SEL_RUN;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.lap1           = lap1;
    assign bus.lap2           = lap2;
    assign bus.lap_count      = lap_count;
    assign bus.display_select = state;
endmodule

// File: tb/tb_lap_controller.sv
// Self-checking bench for lap_controller with a short timeout.
module tb_lap_controller;
    import stopwatch_pkg::*;

    localparam int TW  = 16;
    localparam int TMO = 8;

    typedef struct {
        string       tag;
        logic [15:0] l1;
        logic [15:0] l2;
        logic [1:0]  cnt;
        logic [1:0]  sel;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    lap_controller_if #(.TIME_W(TW)) bus ();

    lap_controller #(.TIME_W(TW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state, then compare.
    task automatic cyc(input string tag, input logic rst, input logic clr,
                       input logic lap, input logic view, input logic [15:0] rt,
                       input logic [15:0] l1, input logic [15:0] l2,
                       input logic [1:0] cnt, input logic [1:0] sel);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        bus.clear        = clr;
        bus.lap_btn      = lap;
        bus.view_btn     = view;
        bus.running_time = rt;
        e.tag = tag; e.l1 = l1; e.l2 = l2; e.cnt = cnt; e.sel = sel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_lap1"}, 32'(bus.lap1), 32'(e.l1));
            chk({e.tag, "_lap2"}, 32'(bus.lap2), 32'(e.l2));
            chk({e.tag, "_cnt"},  32'(bus.lap_count), 32'(e.cnt));
            chk({e.tag, "_sel"},  32'(bus.display_select), 32'(e.sel));
        end
    endtask

    initial begin
        reset = 1'b1; bus.clear = 1'b0; bus.lap_btn = 1'b0; bus.view_btn = 1'b0;
        bus.running_time = 16'h0;

        cyc("rst0", 1, 0, 0, 0, 16'h1111, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("rst1", 1, 0, 0, 0, 16'h1111, 16'h0, 16'h0, 2'd0, 2'b00);

        // view with no laps stays in RUN
        cyc("view_nolap", 0, 0, 0, 1, 16'h0001, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("view_nolap_rel", 0, 0, 0, 0, 16'h0001, 16'h0, 16'h0, 2'd0, 2'b00);

        // three laps, count saturates
        cyc("lapA", 0, 0, 1, 0, 16'h0012, 16'h0012, 16'h0000, 2'd1, 2'b00);
        cyc("lapA_rel", 0, 0, 0, 0, 16'h0020, 16'h0012, 16'h0000, 2'd1, 2'b00);
        cyc("lapB", 0, 0, 1, 0, 16'h0034, 16'h0034, 16'h0012, 2'd2, 2'b00);
        cyc("lapB_rel", 0, 0, 0, 0, 16'h0040, 16'h0034, 16'h0012, 2'd2, 2'b00);
        cyc("lapC", 0, 0, 1, 0, 16'h0056, 16'h0056, 16'h0034, 2'd2, 2'b00);
        cyc("lapC_rel", 0, 0, 0, 0, 16'h0060, 16'h0056, 16'h0034, 2'd2, 2'b00);

        // two laps: RUN -> LAP1 -> LAP2 -> RUN
        cyc("v2_1", 0, 0, 0, 1, 16'h0, 16'h0056, 16'h0034, 2'd2, 2'b01);
        cyc("v2_1r", 0, 0, 0, 0, 16'h0, 16'h0056, 16'h0034, 2'd2, 2'b01);
        cyc("v2_2", 0, 0, 0, 1, 16'h0, 16'h0056, 16'h0034, 2'd2, 2'b10);
        cyc("v2_2r", 0, 0, 0, 0, 16'h0, 16'h0056, 16'h0034, 2'd2, 2'b10);
        cyc("v2_3", 0, 0, 0, 1, 16'h0, 16'h0056, 16'h0034, 2'd2, 2'b00);
        cyc("v2_3r", 0, 0, 0, 0, 16'h0, 16'h0056, 16'h0034, 2'd2, 2'b00);

        // clear from RUN, then one lap: RUN -> LAP1 -> RUN
        cyc("clr_run", 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("clr_run_rel", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("lapD", 0, 0, 1, 0, 16'h0077, 16'h0077, 16'h0, 2'd1, 2'b00);
        cyc("lapD_rel", 0, 0, 0, 0, 16'h0078, 16'h0077, 16'h0, 2'd1, 2'b00);
        cyc("v1_1", 0, 0, 0, 1, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b01);
        cyc("v1_1r", 0, 0, 0, 0, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b01);
        cyc("v1_2", 0, 0, 0, 1, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b00);
        cyc("v1_2r", 0, 0, 0, 0, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b00);

        // timeout: LAP1 held exactly TMO cycles after entry
        cyc("tmo_entry", 0, 0, 0, 1, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b01);
        for (int i = 1; i < TMO; i++)
            cyc($sformatf("tmo_idle%0d", i), 0, 0, 0, 0, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b01);
        cyc("tmo_expire", 0, 0, 0, 0, 16'h0, 16'h0077, 16'h0, 2'd1, 2'b00);

        // second lap, then a view press on the timeout cycle wins
        cyc("lapE", 0, 0, 1, 0, 16'h0099, 16'h0099, 16'h0077, 2'd2, 2'b00);
        cyc("lapE_rel", 0, 0, 0, 0, 16'h0, 16'h0099, 16'h0077, 2'd2, 2'b00);
        cyc("pri_entry", 0, 0, 0, 1, 16'h0, 16'h0099, 16'h0077, 2'd2, 2'b01);
        for (int i = 1; i < TMO; i++)
            cyc($sformatf("pri_idle%0d", i), 0, 0, 0, 0, 16'h0, 16'h0099, 16'h0077, 2'd2, 2'b01);
        cyc("pri_view", 0, 0, 0, 1, 16'h0, 16'h0099, 16'h0077, 2'd2, 2'b10);
        for (int i = 1; i < TMO; i++)
            cyc($sformatf("pri2_idle%0d", i), 0, 0, 0, 0, 16'h0, 16'h0099, 16'h0077, 2'd2, 2'b10);
        cyc("pri2_expire", 0, 0, 0, 0, 16'h0, 16'h0099, 16'h0077, 2'd2, 2'b00);

        // lap button held 20 cycles: one capture only
        cyc("hold_0", 0, 0, 1, 0, 16'h00AA, 16'h00AA, 16'h0099, 2'd2, 2'b00);
        for (int i = 1; i < 20; i++)
            cyc($sformatf("hold_%0d", i), 0, 0, 1, 0, 16'h00BB, 16'h00AA, 16'h0099, 2'd2, 2'b00);
        cyc("hold_rel", 0, 0, 0, 0, 16'h00BB, 16'h00AA, 16'h0099, 2'd2, 2'b00);

        // simultaneous lap+view uses the pre-lap count
        cyc("clr2", 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("clr2_rel", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("sim_c0", 0, 0, 1, 1, 16'h0021, 16'h0021, 16'h0, 2'd1, 2'b00);
        cyc("sim_c0r", 0, 0, 0, 0, 16'h0, 16'h0021, 16'h0, 2'd1, 2'b00);
        cyc("sim_c1", 0, 0, 1, 1, 16'h0022, 16'h0022, 16'h0021, 2'd2, 2'b01);
        cyc("sim_c1r", 0, 0, 0, 0, 16'h0, 16'h0022, 16'h0021, 2'd2, 2'b01);

        // clear in LAP2; events during clear are swallowed
        cyc("to_lap2", 0, 0, 0, 1, 16'h0, 16'h0022, 16'h0021, 2'd2, 2'b10);
        cyc("to_lap2r", 0, 0, 0, 0, 16'h0, 16'h0022, 16'h0021, 2'd2, 2'b10);
        cyc("clr_lap2", 0, 1, 1, 1, 16'h0044, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("clr_drop_held", 0, 0, 1, 1, 16'h0045, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("clr_btn_rel", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 2'b00);

        // reset beats clear; a lap held across reset release fires once
        cyc("lapF", 0, 0, 1, 0, 16'h0055, 16'h0055, 16'h0, 2'd1, 2'b00);
        cyc("rst_clr", 1, 1, 1, 0, 16'h0056, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("rst_hold", 1, 0, 1, 0, 16'h0057, 16'h0, 16'h0, 2'd0, 2'b00);
        cyc("rst_rel_evt", 0, 0, 1, 0, 16'h0066, 16'h0066, 16'h0, 2'd1, 2'b00);
        cyc("rst_rel_hold", 0, 0, 1, 0, 16'h0067, 16'h0066, 16'h0, 2'd1, 2'b00);
        cyc("rst_rel_low", 0, 0, 0, 0, 16'h0068, 16'h0066, 16'h0, 2'd1, 2'b00);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
